multififo_w1_r8: RTL



---
 rtl/multififo_pkg.sv | 18 +
 rtl/multififo_rdlane.sv | 27 ++
 rtl/multififo_w1_r8.sv | 95 +++++++++
 3 files changed

// File: rtl/multififo_pkg.sv
// Shared constants and pointer arithmetic for the multififo family
// (w1_r8 and w8_r1 variants).
package multififo_pkg;

    localparam int MAXREADS = 8;
    localparam int READSW   = 4;

    // Circular pointer advance for depths that need not be a power of two.
    // 32-bit arithmetic leaves headroom for DEPTH up to 65535 plus any lane offset.
    function automatic logic [31:0] wrap_ptr(input logic [31:0] p,
                                             input logic [31:0] n,
                                             input logic [31:0] depth);
        logic [31:0] s;
        s = p + n;
        return (s >= depth) ? (s - depth) : s;
    endfunction

endpackage

// File: rtl/multififo_rdlane.sv
// One show-ahead read lane: lane pointer, lane-valid bit and the gated data word.
module multififo_rdlane
    import multififo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int LANE  = 0,
    parameter int PW    = 4
) (
    input  logic [PW-1:0]     rptr,
    input  logic [READSW-1:0] reads,
    input  logic              oktoread,
    input  logic [WIDTH-1:0]  mem [DEPTH],
    output logic [WIDTH-1:0]  lane_data,
    output logic              lane_valid
);

    localparam int IW = PW - 1;
    localparam logic [READSW-1:0] LANE_N = READSW'(LANE);

    logic [PW-1:0] rptr_k;

    assign rptr_k     = PW'(wrap_ptr(32'(rptr), 32'(LANE), 32'(DEPTH)));
    assign lane_valid = oktoread && (LANE_N < reads);
    assign lane_data  = lane_valid ? mem[rptr_k[IW-1:0]] : '0;

endmodule

// File: rtl/multififo_w1_r8.sv
// Register-array FIFO: one word pushed per cycle, up to eight words popped per cycle
// through show-ahead lanes driven from the registered read pointer.
module multififo_w1_r8
    import multififo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      softreset,
    input  logic                      writes,
    input  logic [WIDTH-1:0]          din,
    input  logic [READSW-1:0]         reads,
    output logic [WIDTH*MAXREADS-1:0] dout,
    output logic [MAXREADS-1:0]       dvalid,
    output logic                      taken,
    output logic                      wready,
    output logic [15:0]               count,
    output logic [15:0]               frees,
    output logic                      err_overflow,
    output logic                      err_underflow
);

    localparam int WIDPTR = $clog2(DEPTH);
    localparam int PW     = WIDPTR + 1;
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    logic [WIDTH-1:0] fifos [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             badread;
    logic             oktoread;
    logic             oktowrite;

    // A pop in the same cycle never frees room for the push: full means full.
    assign badread   = reads > READSW'(MAXREADS);
    assign oktoread  = !badread && (16'(reads) <= count) && !softreset;
    assign oktowrite = writes && (count < DEPTH16) && !softreset;
    assign taken     = oktoread;
    assign wready    = oktowrite;
    assign frees     = DEPTH16 - count;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifos[i] <= '0;
            end
        end else if (softreset) begin
            // Storage is deliberately left intact; only bookkeeping is cleared.
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (oktowrite) begin
                fifos[wptr[WIDPTR-1:0]] <= din;
                wptr <= PW'(wrap_ptr(32'(wptr), 32'd1, 32'(DEPTH)));
            end
            if (oktoread) begin
                rptr <= PW'(wrap_ptr(32'(rptr), 32'(reads), 32'(DEPTH)));
            end
            count <= count + 16'(oktowrite) - (oktoread ? 16'(reads) : 16'd0);
            if (writes && (count == DEPTH16)) begin
                err_overflow <= 1'b1;
            end
            if ((reads != '0) && !oktoread) begin
                err_underflow <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < MAXREADS; k++) begin : g_lane
        multififo_rdlane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .LANE  (k),
            .PW    (PW)
        ) u_lane (
            .rptr       (rptr),
            .reads      (reads),
            .oktoread   (oktoread),
            .mem        (fifos),
            .lane_data  (dout[WIDTH*k +: WIDTH]),
            .lane_valid (dvalid[k])
        );
    end

endmodule
